uart_tx_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares the single USART1 transmit byte interface between NUM_REQ on-chip requesters, e.g. CPU debug console, DMA log channel and LCD/DDR status reporter.
- Sits between requester byte streams and the UART TX core's valid/ready byte input.
- Grants one requester per packet and holds the grant until that requester's last byte is accepted or an idle timeout expires.
- Only one requester's bytes reach the UART at a time, so packets never interleave on the line.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the packet-locked round-robin arbiters.
// This package holds the FSM encoding, the requester limit and the helper
// that sizes grant/pointer fields from a requester count.
package uart_arb_pkg;

  // Upper bound on requesters supported by the arbiter family.
  localparam int NUM_REQ_MAX = 8;

  // Arbiter FSM: IDLE arbitrates, XFER forwards the locked requester.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Width of an index field that addresses n requesters.
  // The result is never 0, so a 2-requester arbiter still gets a 1-bit grant.
  function automatic int grant_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotated-priority picker.
// The search starts at ptr and wraps modulo N. The first set request found
// in that cyclic order wins. The module is kept generic so other shared
// peripherals can reuse it.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = grant_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          found,
  output logic [GW-1:0] idx
);

  logic [GW-1:0] cand;

  // Scan from the farthest offset down to offset 0. A later hit overwrites
  // an earlier one, so the index closest to ptr wins.
  always_comb begin
    found = |req;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = GW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter for a shared UART TX byte input.
// A requester is granted for a whole packet. The grant ends when that
// requester's last byte is accepted, or when the requester has held
// req_valid low for TIMEOUT consecutive cycles. Packets never interleave
// on the line.
//
// Handshake semantics, used on every interface of this block:
// a byte transfers on a rising clock edge where valid and ready are both high.
// Valid must not depend on ready. Once valid is raised, data and last are
// held stable until the transfer happens. Violations are passed through
// unchecked. Ready toward the requesters is taken combinationally from
// tx_ready, so the arbiter adds no storage to the byte path.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 1023,
  parameter  int CW      = 10,
  localparam int GW      = grant_w(NUM_REQ)
) (
  input  logic                 io_clk,
  input  logic                 io_rstn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [0:0]           dbg_state
);

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          xfer;
  logic          g_valid;
  logic          g_last;
  logic          hs;
  logic [GW-1:0] next_ptr;

  // Rotated-priority pick among the current requests, starting at rr_ptr.
  rr_pick #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Mux the granted requester onto the TX port. The mux is gated by XFER
  // state, so an asynchronous reset drops tx_valid and req_ready at once.
  always_comb begin
    xfer      = (state_q == XFER);
    g_valid   = 1'b0;
    g_last    = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        g_valid      = req_valid[i];
        g_last       = req_last[i];
        tx_data      = req_data[8*i +: 8];
        req_ready[i] = xfer & tx_ready;
      end
    end
    tx_valid = xfer & g_valid;
    hs       = tx_valid & tx_ready;
    next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
  end

  // Compute next state: arbitrate in IDLE; in XFER, release on the last
  // handshake or on idle timeout. The counter only advances while the
  // granted requester has no byte pending, so UART backpressure never
  // triggers a release.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    terr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (hs) begin
          cnt_d = '0;
          if (g_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!g_valid) begin
          if (cnt_q >= TO_LAST) begin
            terr_d   = 1'b1;
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge io_clk or negedge io_rstn) begin
    if (!io_rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign grant_id    = grant_q;
  assign busy        = xfer;
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;

  // At most one requester is ever offered ready.
  a_ready_onehot: assert property (@(posedge io_clk) disable iff (!io_rstn)
    $onehot0(req_ready));

  // A byte reaches the UART only while a packet is locked.
  a_valid_busy: assert property (@(posedge io_clk) disable iff (!io_rstn)
    tx_valid |-> busy);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with four requesters and TIMEOUT=8.
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
// Accepted bytes are checked against an expected queue.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 8;
  localparam int CW = 10;

  logic            io_clk = 1'b0;
  logic            io_rstn;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;
  logic [0:0]      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 io_clk = ~io_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .TIMEOUT (TO),
    .CW      (CW)
  ) dut (
    .io_clk      (io_clk),
    .io_rstn     (io_rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]      = v;
    req_data[8*i +: 8] = d;
    req_last[i]       = l;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Samples just before the rising edge, where the inputs have settled.
  always @(negedge io_clk) begin
    #4;
    if (io_rstn && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_extra_byte", exp_q.size(), 1);
      end else begin
        check("tx_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  int bad_cnt;

  initial begin
    io_rstn   = 1'b0;
    req_valid = '1;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;

    // 1. reset with every request raised
    repeat (2) begin
      @(negedge io_clk); #1;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      check("rst_terr", timeout_err, 0);
    end
    @(negedge io_clk); clr_req(); io_rstn = 1'b1; #1;
    check("rel_busy", busy, 0);

    // 2. single requester 2: AA 55 0F(last)
    @(negedge io_clk); set_req(2, 1, 8'hAA, 0); #1;
    check("t2_arb_txv", tx_valid, 0);
    check("t2_arb_busy", busy, 0);
    @(negedge io_clk); #1;
    check("t2_grant", grant_id, 2);
    check("t2_busy", busy, 1);
    check("t2_state", dbg_state, 1);
    check("t2_ready", req_ready, 4'b0100);
    check("t2_d0", tx_data, 8'hAA);
    exp_q.push_back(8'hAA);
    @(negedge io_clk); set_req(2, 1, 8'h55, 0); #1;
    check("t2_d1", tx_data, 8'h55);
    exp_q.push_back(8'h55);
    @(negedge io_clk); set_req(2, 1, 8'h0F, 1); #1;
    check("t2_d2", tx_data, 8'h0F);
    exp_q.push_back(8'h0F);
    // requesters 0 and 3 both ask; the scan starts at index 3
    @(negedge io_clk); set_req(2, 0, 0, 0); set_req(3, 1, 8'h3C, 1); set_req(0, 1, 8'h10, 1); #1;
    check("t2_release_busy", busy, 0);
    @(negedge io_clk); #1;
    check("t2_next_from3", grant_id, 3);
    check("t2_d3", tx_data, 8'h3C);
    exp_q.push_back(8'h3C);

    // 3. fairness: all requesters stream 1-byte packets
    for (int p = 0; p < 6; p++) begin
      @(negedge io_clk);
      if (p == 0) begin
        for (int i = 0; i < NR; i++) set_req(i, 1, 8'h10 + 8'(i), 1);
      end
      #1;
      check("t3_bubble_busy", busy, 0);
      check("t3_bubble_txv", tx_valid, 0);
      @(negedge io_clk); #1;
      check("t3_grant", grant_id, p % 4);
      check("t3_data", tx_data, 8'h10 + 8'(p % 4));
      exp_q.push_back(8'h10 + 8'(p % 4));
    end
    @(negedge io_clk); clr_req(); #1;
    check("t3_idle_busy", busy, 0);
    check("t3_grant_hold", grant_id, 1);

    // 4. packet lock: requester 1 sends 4 bytes, requester 0 waits
    @(negedge io_clk); set_req(1, 1, 8'hA1, 0); #1;
    @(negedge io_clk); #1;
    check("t4_grant1", grant_id, 1);
    exp_q.push_back(8'hA1);
    @(negedge io_clk); set_req(1, 1, 8'hA2, 0); set_req(0, 1, 8'h05, 1); #1;
    check("t4_lock_b2", req_ready, 4'b0010);
    exp_q.push_back(8'hA2);
    @(negedge io_clk); set_req(1, 1, 8'hA3, 0); #1;
    check("t4_lock_b3", req_ready, 4'b0010);
    exp_q.push_back(8'hA3);
    @(negedge io_clk); set_req(1, 1, 8'hA4, 1); #1;
    check("t4_lock_b4", req_ready, 4'b0010);
    check("t4_d4", tx_data, 8'hA4);
    exp_q.push_back(8'hA4);
    @(negedge io_clk); set_req(1, 0, 0, 0); #1;
    check("t4_bubble_busy", busy, 0);
    check("t4_bubble_ready", req_ready, 0);
    @(negedge io_clk); #1;
    check("t4_grant0", grant_id, 0);
    check("t4_ready0", req_ready, 4'b0001);
    check("t4_d0", tx_data, 8'h05);
    exp_q.push_back(8'h05);
    @(negedge io_clk); clr_req(); #1;

    // 5a. timeout: requester 3 sends 0x31 without last, then goes quiet
    @(negedge io_clk); set_req(3, 1, 8'h31, 0); #1;
    @(negedge io_clk); #1;
    check("t5_grant3", grant_id, 3);
    exp_q.push_back(8'h31);
    for (int k = 0; k < TO; k++) begin
      @(negedge io_clk);
      if (k == 0) set_req(3, 0, 0, 0);
      #1;
      check("t5_no_terr_yet", timeout_err, 0);
      check("t5_still_busy", busy, 1);
    end
    @(negedge io_clk); set_req(0, 1, 8'h50, 1); set_req(2, 1, 8'h52, 1); #1;
    check("t5_terr_pulse", timeout_err, 1);
    check("t5_terr_busy", busy, 0);
    @(negedge io_clk); set_req(2, 0, 0, 0); #1;
    check("t5_terr_single", timeout_err, 0);
    check("t5_next_grant0", grant_id, 0);
    check("t5_next_data", tx_data, 8'h50);
    exp_q.push_back(8'h50);
    @(negedge io_clk); clr_req(); #1;

    // 5b. backpressure: valid held, tx_ready low for 2000 cycles
    @(negedge io_clk); set_req(3, 1, 8'h77, 1); tx_ready = 1'b0; #1;
    bad_cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge io_clk); #1;
      if (timeout_err || !busy || !tx_valid || req_ready != 4'b0000) bad_cnt++;
    end
    check("t5_stall_clean", bad_cnt, 0);
    check("t5_stall_grant", grant_id, 3);
    @(negedge io_clk); tx_ready = 1'b1; #1;
    check("t5_stall_ready", req_ready, 4'b1000);
    exp_q.push_back(8'h77);
    @(negedge io_clk); set_req(3, 0, 0, 0); #1;
    check("t5_stall_done", busy, 0);
    check("t5_stall_terr", timeout_err, 0);

    // 6. reset mid-packet (rr_ptr is moved to 2 first)
    @(negedge io_clk); set_req(1, 1, 8'hB1, 1); #1;
    @(negedge io_clk); #1;
    check("t6_grant1", grant_id, 1);
    exp_q.push_back(8'hB1);
    @(negedge io_clk); set_req(1, 0, 0, 0); set_req(2, 1, 8'hC1, 0); #1;
    @(negedge io_clk); #1;
    check("t6_grant2", grant_id, 2);
    exp_q.push_back(8'hC1);
    @(negedge io_clk); set_req(2, 1, 8'hC2, 0); #1;
    exp_q.push_back(8'hC2);
    @(negedge io_clk); set_req(2, 1, 8'hC3, 0); #1;
    check("t6_pre_rst_txv", tx_valid, 1);
    io_rstn = 1'b0; #1;
    check("t6_rst_txv", tx_valid, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_grant", grant_id, 0);
    @(negedge io_clk); set_req(2, 0, 0, 0); #1;
    check("t6_rst_hold_txv", tx_valid, 0);
    @(negedge io_clk); io_rstn = 1'b1; set_req(1, 1, 8'hD1, 1); set_req(3, 1, 8'hD3, 1); #1;
    check("t6_rel_busy", busy, 0);
    @(negedge io_clk); #1;
    check("t6_prio_from0", grant_id, 1);
    check("t6_d1", tx_data, 8'hD1);
    exp_q.push_back(8'hD1);
    @(negedge io_clk); set_req(1, 0, 0, 0); #1;
    check("t6_bubble", busy, 0);
    @(negedge io_clk); #1;
    check("t6_grant3", grant_id, 3);
    exp_q.push_back(8'hD3);
    @(negedge io_clk); clr_req(); #1;
    repeat (2) @(negedge io_clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
